// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent up/down counters (wrap or saturate) plus a one-entry snapshot port.
// Latency: count/wrap/sat update 1 cycle after stimulus; snapshot valid 1 cycle after snap_req.
// Backpressure: snapshot holds until snap_ready; requests arriving while held without snap_ready are dropped.
// Optional COUNTER_BANK_TRACE_EN adds simulation-only wrap/snapshot trace prints.
module counter_bank #(
    parameter int              WIDTH    = 8,
    parameter int              CHANNELS = 4,
    parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
    parameter int              SATURATE = 0,
    localparam int             SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       sat,
    input  logic                      snap_req,
    input  logic [SEL_W-1:0]          snap_sel,
    output logic                      snap_valid,
    output logic [WIDTH-1:0]          snap_data,
    input  logic                      snap_ready
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_bank: WIDTH must be 2..32");
        end
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("counter_bank: CHANNELS must be 1..16");
        end
    endgenerate

    // One spare bit so MAX+1 never aliases back to 0 when MAX = 2^WIDTH-1.
    localparam logic [WIDTH:0] MAX_X = {1'b0, MAX};

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } snap_state_t;

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] wrap_q;
    logic [CHANNELS-1:0] wrap_d;
    logic [CHANNELS-1:0] sat_q;
    logic [CHANNELS-1:0] sat_d;

    logic [WIDTH:0]      cur_x;
    logic [WIDTH:0]      nxt_x;
    logic [WIDTH:0]      ld_x;

    snap_state_t         state_q;
    snap_state_t         state_d;
    logic [WIDTH-1:0]    snap_data_q;
    logic [WIDTH-1:0]    snap_data_d;
    logic [WIDTH-1:0]    sel_val;
    logic                snap_take;

    // Per-channel next state: load beats enable; an idle channel holds count and sat.
    always_comb begin
        wrap_d = '0;
        sat_d  = sat_q;
        cur_x  = '0;
        nxt_x  = '0;
        ld_x   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            cur_x    = {1'b0, cnt_q[i]};
            ld_x     = {1'b0, load_val[i*WIDTH +: WIDTH]};
            nxt_x    = cur_x;
            if (load[i]) begin
                if (ld_x > MAX_X) begin
                    ld_x = MAX_X;
                end
                cnt_d[i] = ld_x[WIDTH-1:0];
                sat_d[i] = (SATURATE != 0) && en[i] && ((ld_x == '0) || (ld_x == MAX_X));
            end else if (en[i]) begin
                if (!dir[i]) begin
                    if (cur_x >= MAX_X) begin
                        if (SATURATE != 0) begin
                            cnt_d[i] = MAX;
                            sat_d[i] = 1'b1;
                        end else begin
                            cnt_d[i]  = '0;
                            wrap_d[i] = 1'b1;
                            sat_d[i]  = 1'b0;
                        end
                    end else begin
                        nxt_x    = cur_x + 1'b1;
                        cnt_d[i] = nxt_x[WIDTH-1:0];
                        sat_d[i] = (SATURATE != 0) && (nxt_x == MAX_X);
                    end
                end else begin
                    if (cur_x == '0) begin
                        if (SATURATE != 0) begin
                            cnt_d[i] = '0;
                            sat_d[i] = 1'b1;
                        end else begin
                            cnt_d[i]  = MAX;
                            wrap_d[i] = 1'b1;
                            sat_d[i]  = 1'b0;
                        end
                    end else begin
                        nxt_x    = cur_x - 1'b1;
                        cnt_d[i] = nxt_x[WIDTH-1:0];
                        sat_d[i] = (SATURATE != 0) && (nxt_x == '0);
                    end
                end
            end
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(snap_sel) == i) begin
                sel_val = cnt_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        snap_take   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    snap_take = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        snap_take = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (snap_take) begin
            snap_data_d = sel_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            wrap_q      <= '0;
            sat_q       <= '0;
            state_q     <= S_IDLE;
            snap_data_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wrap_q      <= wrap_d;
            sat_q       <= sat_d;
            state_q     <= state_d;
            snap_data_q <= snap_data_d;
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign count[g*WIDTH +: WIDTH] = cnt_q[g];
        end
    endgenerate

    assign wrap       = wrap_q;
    assign sat        = sat_q;
    assign snap_valid = (state_q == S_HOLD);
    assign snap_data  = snap_data_q;

`ifdef COUNTER_BANK_TRACE_EN
    logic [SEL_W-1:0] trace_sel_q;

    always @(posedge clock) begin
        if (reset) begin
            trace_sel_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap_q[i]) begin
                    $display("counter_bank ch%0d wrap", i);
                end
            end
            if (snap_valid && snap_ready) begin
                $display("counter_bank snap ch%0d=%0d", trace_sel_q, snap_data_q);
            end
            if (snap_take) begin
                trace_sel_q <= snap_sel;
            end
        end
    end
`endif

endmodule
